// File: rtl/pwd_lock_ctrl_if.sv
// Keypad-side bundle for the password lock: digit/cancel/mode strobes in,
// entry display, status flags and trial count out.
interface pwd_lock_ctrl_if #(
    parameter int DIGITS     = 3,
    parameter int DIGIT_W    = 4,
    parameter int MAX_TRIALS = 3
);
    localparam int EW  = DIGITS * DIGIT_W;
    localparam int CW  = $clog2(DIGITS + 1);
    localparam int TRW = $clog2(MAX_TRIALS + 1);

    logic [DIGIT_W-1:0] data_in;
    logic               digit_valid;
    logic               mode;
    logic               cancel;
    logic [EW-1:0]      entry;
    logic [CW-1:0]      digit_count;
    logic               unlock;
    logic               locked;
    logic               fail;
    logic               set_done;
    logic [TRW-1:0]     trials_left;

    modport master (
        output data_in, digit_valid, mode, cancel,
        input  entry, digit_count, unlock, locked, fail, set_done, trials_left
    );

    modport slave (
        input  data_in, digit_valid, mode, cancel,
        output entry, digit_count, unlock, locked, fail, set_done, trials_left
    );
endinterface

// File: rtl/pwd_lock_ctrl.sv
// Password lock FSM: collects DIGITS keypad digits, checks them against the
// stored password, tracks failed trials with a timed lockout, and re-keys from OPEN.
module pwd_lock_ctrl #(
    parameter int DIGITS      = 3,
    parameter int DIGIT_W     = 4,
    parameter int MAX_TRIALS  = 3,
    parameter int LOCK_CYCLES = 16,
    parameter int OPEN_CYCLES = 8,
    parameter logic [DIGITS*DIGIT_W-1:0] RESET_PWD = '0
) (
    input logic            clock_t,
    input logic            reset_test,
    pwd_lock_ctrl_if.slave bus
);
    localparam int EW   = DIGITS * DIGIT_W;
    localparam int CW   = $clog2(DIGITS + 1);
    localparam int TRW  = $clog2(MAX_TRIALS + 1);
    localparam int TMAX = (OPEN_CYCLES > LOCK_CYCLES) ? OPEN_CYCLES : LOCK_CYCLES;
    localparam int TW   = $clog2(TMAX + 1);

    localparam logic [CW-1:0]  LAST_IDX   = CW'(DIGITS - 1);
    localparam logic [TRW-1:0] TRIALS_MAX = TRW'(MAX_TRIALS);
    localparam logic [TW-1:0]  OPEN_LOAD  = TW'(OPEN_CYCLES);
    localparam logic [TW-1:0]  LOCK_LOAD  = TW'(LOCK_CYCLES);

    typedef enum logic [1:0] {
        ENTRY,
        EVAL,
        OPEN,
        LOCKOUT
    } state_t;

    state_t           state_q, state_d;
    logic [EW-1:0]    stored_q, stored_d;
    logic [EW-1:0]    entry_q, entry_d;
    logic [CW-1:0]    count_q, count_d;
    logic [TRW-1:0]   trials_q, trials_d;
    logic [TW-1:0]    timer_q, timer_d;
    logic             unlock_q, unlock_d;
    logic             locked_q, locked_d;
    logic             fail_q, fail_d;
    logic             set_done_q, set_done_d;

    logic [EW+DIGIT_W-1:0] shift_wide;
    logic [EW-1:0]         entry_shift;
    logic                  last_digit;

    // Open and lockout never overlap, so one down-counter serves both timers.
    always_comb begin
        shift_wide  = {entry_q, bus.data_in};
        entry_shift = shift_wide[EW-1:0];
        last_digit  = (count_q == LAST_IDX);

        state_d    = state_q;
        stored_d   = stored_q;
        entry_d    = entry_q;
        count_d    = count_q;
        trials_d   = trials_q;
        timer_d    = timer_q;
        unlock_d   = unlock_q;
        locked_d   = locked_q;
        fail_d     = 1'b0;
        set_done_d = 1'b0;

        case (state_q)
            ENTRY: begin
                if (bus.cancel) begin
                    entry_d = '0;
                    count_d = '0;
                end else if (bus.digit_valid) begin
                    entry_d = entry_shift;
                    count_d = count_q + 1'b1;
                    if (last_digit) state_d = EVAL;
                end
            end
            EVAL: begin
                entry_d = '0;
                count_d = '0;
                if (entry_q == stored_q) begin
                    state_d  = OPEN;
                    unlock_d = 1'b1;
                    trials_d = TRIALS_MAX;
                    timer_d  = OPEN_LOAD;
                end else begin
                    fail_d = 1'b1;
                    if (trials_q <= TRW'(1)) begin
                        trials_d = '0;
                        state_d  = LOCKOUT;
                        locked_d = 1'b1;
                        timer_d  = LOCK_LOAD;
                    end else begin
                        trials_d = trials_q - 1'b1;
                        state_d  = ENTRY;
                    end
                end
            end
            OPEN: begin
                if (bus.cancel) begin
                    state_d  = ENTRY;
                    unlock_d = 1'b0;
                    entry_d  = '0;
                    count_d  = '0;
                    timer_d  = '0;
                end else if (bus.digit_valid && bus.mode) begin
                    if (last_digit) begin
                        stored_d   = entry_shift;
                        set_done_d = 1'b1;
                        state_d    = ENTRY;
                        unlock_d   = 1'b0;
                        entry_d    = '0;
                        count_d    = '0;
                        timer_d    = '0;
                    end else begin
                        entry_d = entry_shift;
                        count_d = count_q + 1'b1;
                        timer_d = OPEN_LOAD;
                    end
                end else if (timer_q <= TW'(1)) begin
                    // A half-typed new password is discarded on timeout.
                    state_d  = ENTRY;
                    unlock_d = 1'b0;
                    entry_d  = '0;
                    count_d  = '0;
                    timer_d  = '0;
                end else begin
                    timer_d = timer_q - 1'b1;
                end
            end
            LOCKOUT: begin
                if (timer_q <= TW'(1)) begin
                    state_d  = ENTRY;
                    locked_d = 1'b0;
                    trials_d = TRIALS_MAX;
                    timer_d  = '0;
                end else begin
                    timer_d = timer_q - 1'b1;
                end
            end
            default: state_d = ENTRY;
        endcase
    end

    always_ff @(posedge clock_t or negedge reset_test) begin
        if (!reset_test) begin
            state_q    <= ENTRY;
            stored_q   <= RESET_PWD;
            entry_q    <= '0;
            count_q    <= '0;
            trials_q   <= TRIALS_MAX;
            timer_q    <= '0;
            unlock_q   <= 1'b0;
            locked_q   <= 1'b0;
            fail_q     <= 1'b0;
            set_done_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            stored_q   <= stored_d;
            entry_q    <= entry_d;
            count_q    <= count_d;
            trials_q   <= trials_d;
            timer_q    <= timer_d;
            unlock_q   <= unlock_d;
            locked_q   <= locked_d;
            fail_q     <= fail_d;
            set_done_q <= set_done_d;
        end
    end

    assign bus.entry       = entry_q;
    assign bus.digit_count = count_q;
    assign bus.unlock      = unlock_q;
    assign bus.locked      = locked_q;
    assign bus.fail        = fail_q;
    assign bus.set_done    = set_done_q;
    assign bus.trials_left = trials_q;
endmodule

// File: doc/pwd_lock_ctrl.md
Name: pwd_lock_ctrl

Overview:
- Parametrised password-lock controller and the successor of the 3-digit fixed-trial lock path.
- Collects DIGITS keypad digits, compares them with a stored password, and grants or denies access.
- Counts failed trials and enters a timed lockout when trials run out.
- Allows the password to be changed while unlocked. Runs as a single-clock synchronous FSM; key inputs arrive as one-cycle strobes from the debounce front end.

Parameters:
- DIGITS, 3, number of digits per password.
- DIGIT_W, 4, bits per digit.
- MAX_TRIALS, 3, failed attempts allowed before lockout (>=1).
- LOCK_CYCLES, 16, lockout duration in clock cycles (>=1).
- OPEN_CYCLES, 8, idle cycles before OPEN auto-relocks (>=1).
- RESET_PWD, 0, stored password after reset (DIGITS*DIGIT_W bits).

Ports:
- clock_t  in  1  system clock, rising edge.
- reset_test  in  1  asynchronous, active-low reset.
- data_in  in  DIGIT_W  digit value, sampled when digit_valid=1.
- digit_valid  in  1  one-cycle digit strobe.
- mode  in  1  1 = set-password request; meaningful in OPEN only.
- cancel  in  1  one-cycle strobe: clear entry, or relock from OPEN.
- entry  out  DIGITS*DIGIT_W  digits entered so far, for display.
- digit_count  out  clog2(DIGITS+1)  digits held in entry.
- unlock  out  1  high while in OPEN.
- locked  out  1  high while in LOCKOUT.
- fail  out  1  one-cycle pulse on a mismatch.
- set_done  out  1  one-cycle pulse when a new password is stored.
- trials_left  out  clog2(MAX_TRIALS+1)  remaining attempts.

Behaviour:
- All outputs are registered.
- Reset (reset_test=0, any time, including mid-lockout or mid-entry):
  - state=ENTRY; stored=RESET_PWD; entry=0; digit_count=0.
  - unlock=locked=fail=set_done=0; trials_left=MAX_TRIALS; all timers 0.
- Digit shift rule: on an accepted strobe, entry <= {entry[DIGITS*DIGIT_W-DIGIT_W-1:0], data_in} (newest digit in the LSBs) and digit_count increments. Any DIGIT_W value is accepted.
- ENTRY state:
  - digit_valid shifts a digit in.
  - The strobe that makes digit_count reach DIGITS moves the FSM to EVAL on that same edge.
  - cancel clears entry and digit_count; no trial is consumed.
  - cancel and digit_valid in the same cycle: cancel wins, the digit is dropped.
- EVAL state (exactly one cycle):
  - Match (entry == stored): go to OPEN; unlock=1; trials_left=MAX_TRIALS; open timer=OPEN_CYCLES.
  - Mismatch: fail=1 for one cycle; trials_left decrements.
    - If trials_left becomes 0: go to LOCKOUT; locked=1; lock timer=LOCK_CYCLES.
    - Otherwise: return to ENTRY.
  - entry and digit_count are cleared on either outcome.
  - Inputs are ignored during EVAL.
- Latency: the completing strobe is sampled at edge N, EVAL is active in cycle N..N+1, and unlock/fail/locked update at edge N+1.
- OPEN state:
  - The open timer decrements every cycle without an accepted digit. When it reaches 0, go to ENTRY and unlock=0.
  - digit_valid is accepted only when mode=1; each accepted digit reloads the timer to OPEN_CYCLES.
  - When the DIGITS-th digit is accepted: stored <= new entry value; set_done=1 for one cycle; go to ENTRY; unlock=0; entry cleared.
  - digit_valid with mode=0 is ignored and does not reload the timer.
  - cancel: immediate relock (go to ENTRY, unlock=0, partial entry discarded, stored unchanged). cancel beats a simultaneous digit.
- LOCKOUT state:
  - digit_valid, cancel and mode are ignored.
  - The lock timer decrements every cycle. On the edge where it goes 1 -> 0: go to ENTRY; locked=0; trials_left=MAX_TRIALS.
  - locked is therefore high for exactly LOCK_CYCLES cycles.
- Width rules:
  - Timers are sized clog2(max(OPEN_CYCLES, LOCK_CYCLES)+1).
  - trials_left never underflows (the decrement occurs only from values >=1).
  - digit_count never exceeds DIGITS.

Test Plan:
- Reset, then enter digits 0,0,0 (RESET_PWD=0) -> unlock=1 one edge after EVAL; trials_left=3. Hold idle -> unlock drops after 8 cycles.
- Enter 1,2,3 wrong, three times -> fail pulses 3 times, trials_left 3->2->1->0, locked=1 for exactly 16 cycles. Digits strobed during lockout are ignored and digit_count stays 0. After lockout, trials_left=3.
- Unlock with 0,0,0. With mode=1, enter 5,A,3 -> set_done pulse, unlock=0. Enter 0,0,0 -> fail. Enter 5,A,3 -> unlock=1; stored=12'h5A3.
- Enter 4,7, then assert cancel and digit_valid together -> entry=0, digit_count=0, trials_left unchanged. Next 0,0,0 -> unlock.
- Assert reset_test=0 mid-lockout (lock timer=9) -> locked=0, trials_left=3, state ENTRY, stored=RESET_PWD, asynchronously without a clock edge.
- In OPEN, strobe digits with mode=0 -> ignored; the timer still expires after 8 cycles. In OPEN, cancel after one mode=1 digit -> relock, stored unchanged.
